ccff_loader: RTL and testbench
==============================

Name: ccff_loader

Overview:
- Sequences programming of the FPGA fabric configuration chain from a word-wide source (Wishbone/LA-driven) inside the user project area.
- Serialises words onto ccff_head, gates the fabric programming clock per shifted bit, and counts exactly BITSTREAM_SIZE shifts.
- A chain self-test mode launches a single '1' marker and checks that it emerges on ccff_tail after exactly BITSTREAM_SIZE shifts.

Parameters:
- BITSTREAM_SIZE, 29696: number of flops in the configuration chain.
- WORD_W, 32: input word width; bits are shifted MSB first.
- CNT_W, 16: shift counter width; must satisfy 2**CNT_W > BITSTREAM_SIZE+3.

Ports:
- prog_clk  in  1  single clock; all logic rises on posedge.
- pReset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- test_mode  in  1  sampled at start; 1 = marker self-test, 0 = program.
- abort  in  1  one-cycle pulse; cancels any run.
- wdata  in  WORD_W  bitstream word.
- wvalid  in  1  wdata valid.
- wready  out  1  loader accepts wdata this cycle.
- ccff_head  out  1  serial data into the chain.
- ccff_tail  in  1  serial data out of the chain.
- prog_clk_en  out  1  enable to the prog clock gate; the chain shifts at the end of each cycle where this is 1.
- busy  out  1  run in progress.
- done  out  1  sticky; the last run completed without error.
- error  out  1  sticky; the last run failed its tail check.
- bit_count  out  CNT_W  number of shift cycles issued in the current or last run.

Behaviour:
- Reset: state IDLE; all outputs 0; buffers empty.
- States: IDLE, PROG, TEST, DONE, ERR.
- Output decode: busy=1 in PROG/TEST. done=1 only in DONE; error=1 only in ERR.
- IDLE --start & !abort--> PROG or TEST.
  - On entry: clear bit_count, done and error.
  - start is ignored when not in IDLE/DONE/ERR.
  - DONE and ERR accept start like IDLE.
- Word path:
  - A shift register holds the current word; one prefetch register holds the next.
  - wready = prefetch empty & state==PROG.
  - A word transfers on wvalid & wready.
  - The prefetch moves into the shift register in the same cycle that the last bit of the current word shifts.
- PROG shift cycle:
  - Occurs when the shift register holds an unconsumed bit.
  - ccff_head = current MSB; prog_clk_en=1; bit_count+1; shift left.
  - With no bit available: prog_clk_en=0, ccff_head holds its last value, count is unchanged (stall, no underflow error).
- PROG -> DONE:
  - Triggered after the shift cycle with bit_count reaching BITSTREAM_SIZE.
  - Unused bits of the final word are discarded.
  - wready=0 after this point.
  - prog_clk_en=0 from the next cycle.
- TEST:
  - No word input.
  - Every cycle is a shift cycle (prog_clk_en=1).
  - ccff_head=1 in the first cycle (k=0), 0 afterwards.
- Tail check in TEST (k = bit_count before increment):
  - ccff_tail must be 0 for k in 1..BITSTREAM_SIZE-1.
  - ccff_tail must be 1 at k=BITSTREAM_SIZE.
  - ccff_tail must be 0 at k=BITSTREAM_SIZE+1 and k=BITSTREAM_SIZE+2.
  - k=0 is not checked.
- TEST exit:
  - Any mismatch -> ERR next cycle, with prog_clk_en=0 and bit_count frozen at the failing k+1.
  - Otherwise -> DONE after k=BITSTREAM_SIZE+2 (bit_count=BITSTREAM_SIZE+3).
- abort:
  - From any state -> IDLE next cycle.
  - Buffers flush; prog_clk_en=0; done=error=0; bit_count holds.
  - abort beats start in the same cycle.
- Reset mid-run: immediate return to the reset values.

Decomposition:
- ccff_loader_pkg holds:
  - state enum;
  - BITSTREAM_SIZE default;
  - TAIL_CHECK_CYCLES=3 for the three tail-check cycles k=BITSTREAM_SIZE..BITSTREAM_SIZE+2;
  - a function computing the required CNT_W.
- One natural sub-module, ccff_word_buffer:
  - prefetch register plus shift register;
  - bit-remaining counter;
  - wvalid/wready logic;
  - pop/bit outputs.
- The FSM and tail checker stay in ccff_loader.

Test Plan:
- Program, BITSTREAM_SIZE=64, WORD_W=32, two words 0xA5A5A5A5 and 0x0000FFFF, wvalid always high -> exactly 64 prog_clk_en cycles; ccff_head sequence equals the words MSB-first; done=1; bit_count=64; wready=0 afterwards.
- Program with wvalid gaps of 5 cycles between words -> prog_clk_en low during gaps; still exactly 64 enabled cycles; head order intact; done=1.
- Test mode against a 64-flop shift-register model -> tail 1 only at k=64; done=1; error=0; bit_count=67.
- Test mode with a 63-flop model -> tail 1 at k=63; error=1; ERR entered; prog_clk_en low afterwards; bit_count=64.
- abort at bit_count=20 during PROG -> IDLE; prog_clk_en=0 next cycle; done=error=0. A following start re-runs from bit_count=0 to done.
- pReset asserted mid-TEST -> outputs 0 asynchronously. start in the same cycle as abort -> remains IDLE.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROG,
    S_TEST,
    S_DONE,
    S_ERR
  } state_t;

  localparam int BITSTREAM_SIZE_DEF = 29696;
  // Marker must be seen at k=SIZE and the two following cycles must be clean.
  localparam int TAIL_CHECK_CYCLES = 3;

  function automatic int cnt_w_for(input int size);
    int w;
    w = 31;
    for (int i = 30; i >= 1; i--) begin
      if ((2 ** i) > (size + TAIL_CHECK_CYCLES)) w = i;
    end
    return w;
  endfunction

endpackage

// File: rtl/ccff_word_buffer.sv
// Prefetch register feeding an MSB-first shift register; a word moves from
// prefetch to shift register when the shifter is empty or on its last bit.
module ccff_word_buffer #(
  parameter int WORD_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_en,
  input  logic              i_pop,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_wvalid,
  output logic              o_wready,
  output logic              o_bit_vld,
  output logic              o_bit
);

  localparam int BC_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] r_pre;
  logic [BC_W-1:0]   r_left;
  logic              r_pre_vld;
  logic              w_accept;
  logic              w_last;
  logic              w_load;

  assign o_wready  = i_en & ~r_pre_vld;
  assign w_accept  = o_wready & i_wvalid;
  assign o_bit_vld = (r_left != '0);
  assign o_bit     = r_shift[WORD_W-1];
  assign w_last    = i_pop & (r_left == BC_W'(1));
  assign w_load    = r_pre_vld & ((r_left == '0) | w_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= '0;
      r_pre     <= '0;
      r_left    <= '0;
      r_pre_vld <= 1'b0;
    end else if (i_flush) begin
      r_shift   <= '0;
      r_left    <= '0;
      r_pre_vld <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pre     <= i_wdata;
        r_pre_vld <= 1'b1;
      end else if (w_load) begin
        r_pre_vld <= 1'b0;
      end
      if (w_load) begin
        r_shift <= r_pre;
        r_left  <= BC_W'(WORD_W);
      end else if (i_pop & o_bit_vld) begin
        r_shift <= {r_shift[WORD_W-2:0], 1'b0};
        r_left  <= r_left - BC_W'(1);
      end
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: shifts BITSTREAM_SIZE bits onto ccff_head with a
// per-bit clock enable, or runs a single-marker chain self-test on ccff_tail.
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int BITSTREAM_SIZE = BITSTREAM_SIZE_DEF,
  parameter int WORD_W         = 32,
  parameter int CNT_W          = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              test_mode,
  input  logic              abort,
  input  logic [WORD_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_clk_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count
);

  localparam logic [CNT_W-1:0] L_SIZE = CNT_W'(BITSTREAM_SIZE);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(BITSTREAM_SIZE + TAIL_CHECK_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_head;
  logic             w_head;
  logic             w_shift;
  logic             w_bit_vld;
  logic             w_bit;
  logic             w_tail_bad;
  logic             w_flush;
  logic             w_pop;

  assign w_flush = abort | (r_state != S_PROG);
  assign w_pop   = w_shift & (r_state == S_PROG);

  ccff_word_buffer #(.WORD_W(WORD_W)) u_buf (
    .i_clk     (prog_clk),
    .i_rst_n   (pReset),
    .i_flush   (w_flush),
    .i_en      (r_state == S_PROG),
    .i_pop     (w_pop),
    .i_wdata   (wdata),
    .i_wvalid  (wvalid),
    .o_wready  (wready),
    .o_bit_vld (w_bit_vld),
    .o_bit     (w_bit)
  );

  // k=0 launches the marker and is never checked; the tail must carry it only at k=SIZE.
  assign w_tail_bad = (r_cnt != '0) & (ccff_tail != (r_cnt == L_SIZE));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift     = 1'b0;
    w_head      = r_head;
    case (r_state)
      S_PROG: begin
        if (w_bit_vld) begin
          w_shift   = 1'b1;
          w_head    = w_bit;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_cnt_nxt == L_SIZE) w_state_nxt = S_DONE;
        end
      end
      S_TEST: begin
        w_shift   = 1'b1;
        w_head    = (r_cnt == '0);
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_tail_bad)           w_state_nxt = S_ERR;
        else if (r_cnt == L_LAST) w_state_nxt = S_DONE;
      end
      default: ;
    endcase
    if (start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR)) begin
      w_state_nxt = test_mode ? S_TEST : S_PROG;
      w_cnt_nxt   = '0;
    end
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = r_cnt;
      w_shift     = 1'b0;
      w_head      = r_head;
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_head  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_shift) r_head <= w_head;
    end
  end

  assign ccff_head   = w_head;
  assign prog_clk_en = w_shift;
  assign busy        = (r_state == S_PROG) | (r_state == S_TEST);
  assign done        = (r_state == S_DONE);
  assign error       = (r_state == S_ERR);
  assign bit_count   = r_cnt;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader with a queue scoreboard on the shifted head bits.
module tb_ccff_loader;

  localparam int SIZE = 64;
  localparam int WW   = 32;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          pReset = 1'b0;
  logic          start = 1'b0;
  logic          test_mode = 1'b0;
  logic          abort = 1'b0;
  logic [WW-1:0] wdata = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic          ccff_head;
  logic          ccff_tail;
  logic          prog_clk_en;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] bit_count;

  logic [63:0]   chain;
  logic          chain_clr = 1'b0;
  int            chain_len = 64;

  bit            expq[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            stall_cnt = 0;
  logic          last_head = 1'b0;

  ccff_loader #(.BITSTREAM_SIZE(SIZE), .WORD_W(WW), .CNT_W(CW)) dut (
    .prog_clk    (clk),
    .pReset      (pReset),
    .start       (start),
    .test_mode   (test_mode),
    .abort       (abort),
    .wdata       (wdata),
    .wvalid      (wvalid),
    .wready      (wready),
    .ccff_head   (ccff_head),
    .ccff_tail   (ccff_tail),
    .prog_clk_en (prog_clk_en),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .bit_count   (bit_count)
  );

  always #5 clk = ~clk;

  // Configuration chain model of programmable length.
  always @(posedge clk or negedge pReset) begin
    if (!pReset || chain_clr) chain <= '0;
    else if (prog_clk_en)     chain <= {chain[62:0], ccff_head};
  end
  assign ccff_tail = chain[6'(chain_len - 1)];

  // Monitor: every enabled cycle must match the next expected head bit.
  always @(negedge clk) begin
    if (!pReset) begin
      last_head = 1'b0;
    end else if (prog_clk_en) begin
      n_vec++;
      if (expq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_shift: head=%0b at bit_count=%0d, expected no shift", ccff_head, bit_count);
      end else begin
        bit e;
        e = expq.pop_front();
        if (ccff_head !== e) begin
          n_err++;
          $display("FAIL head_bit: got %0b expected %0b at bit_count=%0d", ccff_head, e, bit_count);
        end
      end
      last_head = ccff_head;
    end else if (busy) begin
      stall_cnt++;
      n_vec++;
      if (ccff_head !== last_head) begin
        n_err++;
        $display("FAIL head_hold: got %0b expected %0b during stall", ccff_head, last_head);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) expq.push_back(w[i]);
  endtask

  task automatic pulse_start(input logic tm);
    start = 1'b1;
    test_mode = tm;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int t;
    t = 0;
    wdata = w;
    wvalid = 1'b1;
    while (!wready && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) chk("wready_timeout", 32'd1, 32'd0);
    tick();
    wvalid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    while (busy && t < limit) begin
      tick();
      t++;
    end
    if (t >= limit) chk("run_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_prog(input int gap, input bit keep_vld);
    push_word(32'hA5A5_A5A5);
    push_word(32'h0000_FFFF);
    pulse_start(1'b0);
    send_word(32'hA5A5_A5A5);
    if (gap > 0) repeat (32 + gap) @(posedge clk);
    #1;
    send_word(32'h0000_FFFF);
    if (keep_vld) begin
      wvalid = 1'b1;
      wdata  = 32'hDEAD_BEEF;
    end
    wait_idle(400);
    chk("prog_done", 32'(done), 32'd1);
    chk("prog_error", 32'(error), 32'd0);
    chk("prog_bit_count", 32'(bit_count), 32'd64);
    chk("prog_wready_after", 32'(wready), 32'd0);
    repeat (3) tick();
    wvalid = 1'b0;
    chk("prog_all_bits_shifted", 32'(expq.size()), 32'd0);
  endtask

  task automatic run_test(input int len, input int nexp);
    chain_len = len;
    chain_clr = 1'b1;
    tick();
    chain_clr = 1'b0;
    expq.push_back(1'b1);
    for (int i = 1; i < nexp; i++) expq.push_back(1'b0);
    pulse_start(1'b1);
    wait_idle(200);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_bit_count", 32'(bit_count), 32'd0);
    chk("rst_prog_clk_en", 32'(prog_clk_en), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_head", 32'(ccff_head), 32'd0);
    tick();
    pReset = 1'b1;
    tick();

    // start together with abort leaves the loader idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_wready", 32'(wready), 32'd0);
    tick();
    chk("start_abort_en", 32'(prog_clk_en), 32'd0);

    // continuous words
    run_prog(0, 1'b1);

    // gapped words: the shifter must stall with the head held
    stall_cnt = 0;
    run_prog(5, 1'b0);
    chk("gap_stalled", 32'(stall_cnt >= 5), 32'd1);

    // self-test on a correctly sized chain
    run_test(64, 67);
    chk("test64_done", 32'(done), 32'd1);
    chk("test64_error", 32'(error), 32'd0);
    chk("test64_bit_count", 32'(bit_count), 32'd67);
    chk("test64_all_shifted", 32'(expq.size()), 32'd0);

    // self-test on a short chain fails at k=63
    run_test(63, 64);
    chk("test63_error", 32'(error), 32'd1);
    chk("test63_done", 32'(done), 32'd0);
    chk("test63_bit_count", 32'(bit_count), 32'd64);
    tick();
    chk("test63_en_low", 32'(prog_clk_en), 32'd0);
    chk("test63_all_shifted", 32'(expq.size()), 32'd0);

    // abort mid-program at bit_count=20, then a clean rerun
    push_word(32'hA5A5_A5A5);
    pulse_start(1'b0);
    chk("abort_prog_error_cleared", 32'(error), 32'd0);
    send_word(32'h1234_5678);
    expq.delete();
    push_word(32'h1234_5678);
    begin
      int t;
      t = 0;
      while (bit_count != 20 && t < 100) begin
        tick();
        t++;
      end
      if (t >= 100) chk("abort_wait_timeout", 32'd1, 32'd0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_en", 32'(prog_clk_en), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_error", 32'(error), 32'd0);
    chk("abort_bit_count", 32'(bit_count), 32'd20);
    chk("abort_shifted_20", 32'(expq.size()), 32'd12);
    expq.delete();
    tick();
    run_prog(0, 1'b0);

    // asynchronous reset in the middle of a self-test
    chain_clr = 1'b1;
    tick();
    chain_clr = 1'b0;
    chain_len = 64;
    expq.push_back(1'b1);
    for (int i = 1; i < 67; i++) expq.push_back(1'b0);
    pulse_start(1'b1);
    repeat (10) tick();
    #1;
    pReset = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_en", 32'(prog_clk_en), 32'd0);
    chk("midrst_bit_count", 32'(bit_count), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    chk("midrst_head", 32'(ccff_head), 32'd0);
    expq.delete();
    tick();
    pReset = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
